// File: rtl/tx_serializer.sv
// -----------------------------------------------------------------------------
// tx_serializer
//   Parallel-to-serial front end for a DDR output stage. Takes WIDTH-bit words
//   over a valid/ready handshake and emits two bits per clock, LSB first:
//   beat k carries dout_even = word[2k] and dout_odd = word[2k+1].
//   A one-deep holding register lets the next word queue up while the current
//   word shifts out, so back-to-back words stream with no idle beat.
//
//   Optional feature (macro TX_SERIALIZER_PRBS_IDLE_EN): idle pairs come from
//   a PRBS7 LFSR (x^7+x^6+1, seed 7'h7F) instead of constant zeros.
//
// Ports
//   clk        : clock, all state on posedge
//   rst        : asynchronous active-high reset
//   din        : parallel word to serialize
//   din_valid  : din holds a word
//   din_ready  : word accepted this cycle if din_valid (combinational)
//   dout_even  : first-half-period bit of the current pair (registered)
//   dout_odd   : second-half-period bit of the current pair (registered)
//   dout_valid : current pair carries word data (registered)
//   underflow  : one-cycle pulse when the stream runs dry (registered)
// -----------------------------------------------------------------------------
module tx_serializer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             dout_even,
  output logic             dout_odd,
  output logic             dout_valid,
  output logic             underflow
);

  localparam int             BEATS = WIDTH / 2;
  localparam int             CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0]  LAST  = CW'(BEATS - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [WIDTH-1:0] shreg, shreg_d;
  logic [WIDTH-1:0] hold, hold_d;
  logic             hold_full, hold_full_d;
  logic             even_d, odd_d, valid_d, uf_d;
  logic             xfer;
  logic             idle_even, idle_odd;

  assign din_ready = !hold_full && !rst;
  assign xfer      = din_valid && din_ready;

`ifdef TX_SERIALIZER_PRBS_IDLE_EN
  // Two LFSR steps per idle cycle: the even bit is taken from the current
  // state, the odd bit from the state after one step.
  logic [6:0] lfsr, lfsr_d, lfsr_s1, lfsr_s2;
  assign lfsr_s1   = {lfsr[5:0],    lfsr[6]    ^ lfsr[5]};
  assign lfsr_s2   = {lfsr_s1[5:0], lfsr_s1[6] ^ lfsr_s1[5]};
  assign idle_even = lfsr[6];
  assign idle_odd  = lfsr_s1[6];
`else
  assign idle_even = 1'b0;
  assign idle_odd  = 1'b0;
`endif

  // Next-state / next-output logic. The shifter always holds the bits that
  // follow the pair currently on the outputs, so shreg[1:0] is the next beat.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    shreg_d     = shreg;
    hold_d      = hold;
    hold_full_d = hold_full;
    even_d      = 1'b0;
    odd_d       = 1'b0;
    valid_d     = 1'b0;
    uf_d        = 1'b0;
`ifdef TX_SERIALIZER_PRBS_IDLE_EN
    lfsr_d      = lfsr;
`endif
    case (state)
      IDLE: begin
        if (xfer) begin
          state_d = SHIFT;
          cnt_d   = '0;
          shreg_d = din >> 2;
          even_d  = din[0];
          odd_d   = din[1];
          valid_d = 1'b1;
        end else begin
          even_d  = idle_even;
          odd_d   = idle_odd;
`ifdef TX_SERIALIZER_PRBS_IDLE_EN
          lfsr_d  = lfsr_s2;
`endif
        end
      end
      SHIFT: begin
        valid_d = 1'b1;
        if (cnt != LAST) begin
          cnt_d   = cnt + 1'b1;
          shreg_d = shreg >> 2;
          even_d  = shreg[0];
          odd_d   = shreg[1];
          if (xfer) begin
            hold_d      = din;
            hold_full_d = 1'b1;
          end
        end else if (hold_full) begin
          // din_ready is low here, so no transfer can collide with the reload
          cnt_d       = '0;
          shreg_d     = hold >> 2;
          even_d      = hold[0];
          odd_d       = hold[1];
          hold_full_d = 1'b0;
        end else if (xfer) begin
          // hold empty: new word bypasses straight into the shifter
          cnt_d   = '0;
          shreg_d = din >> 2;
          even_d  = din[0];
          odd_d   = din[1];
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
          valid_d = 1'b0;
          uf_d    = 1'b1;
          even_d  = idle_even;
          odd_d   = idle_odd;
`ifdef TX_SERIALIZER_PRBS_IDLE_EN
          lfsr_d  = lfsr_s2;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
      dout_even  <= 1'b0;
      dout_odd   <= 1'b0;
      dout_valid <= 1'b0;
      underflow  <= 1'b0;
`ifdef TX_SERIALIZER_PRBS_IDLE_EN
      lfsr       <= 7'h7F;
`endif
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      shreg      <= shreg_d;
      hold       <= hold_d;
      hold_full  <= hold_full_d;
      dout_even  <= even_d;
      dout_odd   <= odd_d;
      dout_valid <= valid_d;
      underflow  <= uf_d;
`ifdef TX_SERIALIZER_PRBS_IDLE_EN
      lfsr       <= lfsr_d;
`endif
    end
  end

endmodule

// File: doc/tx_serializer.md
TX_SERIALIZER -- requirements
Module: tx_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning the parallel word width in bits; must be even and >= 4.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port din  input  WIDTH  parallel word to serialize.
REQ-005 SHALL have port din_valid  input  1  din holds a word to transfer.
REQ-006 SHALL have port din_ready  output  1  block can accept a word this cycle.
REQ-007 SHALL have port dout_even  output  1  first-half-period bit of the current pair, feeding the downstream DDR latch/mux stage.
REQ-008 SHALL have port dout_odd  output  1  second-half-period bit of the current pair.
REQ-009 SHALL have port dout_valid  output  1  current pair carries word data.
REQ-010 SHALL have port underflow  output  1  one-cycle pulse when data stream runs dry.

Function
REQ-011 SHALL emit 2 bits per clk, LSB first: beat k drives dout_even = word[2k] and dout_odd = word[2k+1], k = 0..WIDTH/2-1.
REQ-012 SHALL implement states IDLE and SHIFT, a beat counter 0..WIDTH/2-1, a shift register and one holding register.
REQ-013 SHALL transfer a word on a posedge with din_valid && din_ready; din_ready = !hold_full && !rst.
REQ-014 SHALL, on a transfer in IDLE, load the word directly into the shifter, enter SHIFT, and present beat 0 in the cycle after that edge (1-cycle latency).
REQ-015 SHALL, on a transfer in SHIFT before the last beat, store the word in the holding register.
REQ-016 SHALL, at the last-beat edge with hold full, move the held word into the shifter and present its beat 0 next cycle with no gap; din_ready rises the cycle after.
REQ-017 SHALL, at the last-beat edge with hold empty and a simultaneous transfer, bypass the new word straight into the shifter with no gap.
REQ-018 SHALL, at the last-beat edge with no next word, return to IDLE and assert underflow for exactly one cycle.
REQ-019 SHALL drive dout_valid = 1 in every SHIFT beat and 0 in IDLE; all outputs except din_ready SHALL be registered.
REQ-020 SHALL preserve word order; no word accepted by handshake SHALL be dropped or duplicated.

Reset
REQ-021 SHALL, while rst is high, force dout_even = 0, dout_odd = 0, dout_valid = 0, underflow = 0, din_ready = 0, state IDLE, counter 0, hold empty.
REQ-022 SHALL, on reset mid-word, discard shifter and hold contents immediately, with no underflow pulse on release.
REQ-023 SHALL assert din_ready in the first cycle after rst deasserts.

Configuration
REQ-024 SHALL, with macro TX_SERIALIZER_PRBS_IDLE_EN defined, drive idle pairs (dout_valid = 0) from a PRBS7 LFSR (x^7+x^6+1, seed 7'h7F, out = lfsr[6], feedback lfsr[6]^lfsr[5] into LSB, advanced 2 bits per IDLE cycle: even bit first, then odd), reseeded by rst and frozen in SHIFT.
REQ-025 SHALL, without TX_SERIALIZER_PRBS_IDLE_EN, drive dout_even = dout_odd = 0 in IDLE and contain no LFSR logic.

Verification
REQ-026 SHALL cover: WIDTH=16, single word 16'hA5C3 -> 8 beats (even,odd) = (1,1),(0,0),(0,0),(1,1),(1,0),(1,0),(0,1),(0,1) with dout_valid=1, then underflow=1 for one cycle, dout_valid=0.
REQ-027 SHALL cover: words 16'h0001, 16'h8000 with din_valid held high -> 16 consecutive dout_valid cycles, beat 0 = (1,0), beat 15 = (0,1), no underflow between the two words.
REQ-028 SHALL cover: three words offered back-to-back -> din_ready low while hold full, all three output in order, exactly one underflow after the third.
REQ-029 SHALL cover: rst asserted at beat 3 of a word -> all outputs 0 and din_ready 0 asynchronously, IDLE after release, no underflow, next word output intact.
REQ-030 SHALL cover: with TX_SERIALIZER_PRBS_IDLE_EN, first three idle pairs after reset = (1,1),(1,1),(1,1) with dout_valid=0; without the macro, idle pairs = (0,0).
